// File: rtl/axi_interconnect_fifogen_pkg.sv
// Shared types and pointer-code helpers for the interconnect's generated async FIFOs.
// Helpers work on a wide zero-extended word; callers cast the result to pointer width.
package axi_interconnect_fifogen_pkg;

    localparam int PTR_MAX_W = 32;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } buf_state_t;

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros of a zero-extended Gray code leave the low bits unchanged.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/axi_interconnect_fifogen_rdbuf.sv
// Two-entry first-word-fall-through output buffer; entry 0 is always the head.
// A push arrives one cycle after the RAM read; the issuer guarantees no push in S_TWO.
module axi_interconnect_fifogen_rdbuf
    import axi_interconnect_fifogen_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          m_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic [1:0]    occ,
    output logic          pop
);

    buf_state_t    state;
    buf_state_t    state_nxt;
    logic [DW-1:0] ent0;
    logic [DW-1:0] ent1;

    assign m_valid = (state != S_EMPTY);
    assign pop     = m_valid && m_ready;
    assign occ     = state;
    assign m_data  = ent0;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (push) state_nxt = S_ONE;
            S_ONE: begin
                if (push && !pop) begin
                    state_nxt = S_TWO;
                end else if (!push && pop) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO:   if (pop) state_nxt = S_ONE;
            default: state_nxt = S_EMPTY;
        endcase
    end

    // Storage stage: push lands at the tail, pop shifts entry 1 into the head.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case (state)
                S_EMPTY: if (push) ent0 <= push_data;
                S_ONE: begin
                    if (push && pop) begin
                        ent0 <= push_data;
                    end else if (push) begin
                        ent1 <= push_data;
                    end
                end
                S_TWO:   if (pop) ent0 <= ent1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/axi_interconnect_fifogen_rdctrl.sv
// Read-side controller of the generated async FIFO: write-pointer Gray decode pipeline,
// read pointers, RAM read issue, FWFT output buffer and level/error status.
module axi_interconnect_fifogen_rdctrl
    import axi_interconnect_fifogen_pkg::*;
#(
    parameter int AW        = 4,
    parameter int DW        = 32,
    parameter int G2B_PIPE  = 1,
    parameter int AEMPTY_TH = 2,
    parameter int U_DLY     = 1
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic [AW:0]   wptr_gray_sync,
    output logic [AW:0]   rptr_gray,
    output logic          ram_ren,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          empty,
    output logic          aempty,
    output logic [AW:0]   rd_level,
    output logic          ptr_err
);

    localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AE_TH  = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wptr_bin_p0;
    logic [AW:0] wptr_bin_pn;
    logic [AW:0] rptr_bin;
    logic [AW:0] rptr_bin_nxt;
    logic [AW:0] avail_raw;
    logic [AW:0] avail;
    logic        bad_ptr;
    logic        pend;
    logic        pop;
    logic [1:0]  occ;
    logic [2:0]  room;

    // U_DLY is accepted for compatibility with delayed-NBA builds; no delay is modelled here.
    if (U_DLY < 0) begin : g_udly_unused
    end

    assign wptr_bin_p0 = (AW+1)'(gray2bin(PTR_MAX_W'(wptr_gray_sync)));

    // Decode pipeline stage(s): a stale value only under-reports the available words.
    if (G2B_PIPE == 0) begin : g_g2b_comb
        assign wptr_bin_pn = wptr_bin_p0;
    end else begin : g_g2b_pipe
        logic [AW:0] stg_p1 [G2B_PIPE];
        always_ff @(posedge clk_sys) begin
            if (rst) begin
                for (int k = 0; k < G2B_PIPE; k++) stg_p1[k] <= '0;
            end else begin
                stg_p1[0] <= wptr_bin_p0;
                for (int k = 1; k < G2B_PIPE; k++) stg_p1[k] <= stg_p1[k-1];
            end
        end
        assign wptr_bin_pn = stg_p1[G2B_PIPE-1];
    end

    // An inconsistent pointer pair is never trusted, not even in the cycle it appears.
    assign avail_raw = wptr_bin_pn - rptr_bin;
    assign bad_ptr   = (avail_raw > DEPTH);
    assign avail     = (ptr_err || bad_ptr) ? '0 : avail_raw;

    assign room         = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    assign ram_ren      = !rst && (avail != '0) && (room < 3'd2);
    assign ram_raddr    = rptr_bin[AW-1:0];
    assign rptr_bin_nxt = ram_ren ? (rptr_bin + PTR_ONE) : rptr_bin;

    // Issue stage: pointers advance with the read, pend marks the word due next cycle.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
            pend      <= 1'b0;
            ptr_err   <= 1'b0;
        end else begin
            rptr_bin  <= rptr_bin_nxt;
            rptr_gray <= (AW+1)'(bin2gray(PTR_MAX_W'(rptr_bin_nxt)));
            pend      <= ram_ren;
            ptr_err   <= ptr_err | bad_ptr;
        end
    end

    axi_interconnect_fifogen_rdbuf #(
        .DW(DW)
    ) u_rdbuf (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .push      (pend),
        .push_data (ram_rdata),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .occ       (occ),
        .pop       (pop)
    );

    assign rd_level = rst ? '0
                    : (avail + {{AW{1'b0}}, pend} + {{(AW-1){1'b0}}, occ});
    assign aempty   = (rd_level <= AE_TH);
    assign empty    = !m_valid;

endmodule

// File: tb/tb_axi_interconnect_fifogen_rdctrl.sv
// Bench for the FIFO read controller: a behavioural write side and RAM feed the DUT,
// a scoreboard queue holds written words and a negedge monitor checks every pop.
module tb_axi_interconnect_fifogen_rdctrl;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int TH = 2;

    logic          clk_sys = 1'b0;
    logic          rst = 1'b1;
    logic [AW:0]   wptr_gray_sync = '0;
    logic [AW:0]   rptr_gray;
    logic          ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          empty;
    logic          aempty;
    logic [AW:0]   rd_level;
    logic          ptr_err;

    always #5 clk_sys = ~clk_sys;

    axi_interconnect_fifogen_rdctrl #(
        .AW(AW), .DW(DW), .G2B_PIPE(1), .AEMPTY_TH(TH), .U_DLY(1)
    ) dut (
        .clk_sys        (clk_sys),
        .rst            (rst),
        .wptr_gray_sync (wptr_gray_sync),
        .rptr_gray      (rptr_gray),
        .ram_ren        (ram_ren),
        .ram_raddr      (ram_raddr),
        .ram_rdata      (ram_rdata),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .empty          (empty),
        .aempty         (aempty),
        .rd_level       (rd_level),
        .ptr_err        (ptr_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] gray5(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    function automatic int g2b5(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return int'(b);
    endfunction

    // Reference write side: RAM contents, write pointer and the words owed to the reader.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] exp_q [$];
    int            wptr = 0;

    task automatic write_word(input logic [DW-1:0] d);
        mem[wptr % 16] = d;
        exp_q.push_back(d);
        wptr = (wptr + 1) % 32;
        wptr_gray_sync = gray5(wptr);
    endtask

    always @(posedge clk_sys) begin
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    // Monitor: words visible to the reader are those written one cycle ago (decode latency).
    bit            mon_en = 1'b0;
    int            wvis = 0;
    int            pops = 0;
    int            issued = 0;
    int            mlvl;
    logic [DW-1:0] mexp;

    always @(posedge clk_sys) begin
        if (rst) begin
            wvis = 0;
            pops = 0;
            issued = 0;
        end else begin
            wvis = wptr;
        end
    end

    always @(negedge clk_sys) begin
        if (mon_en && !rst) begin
            mlvl = (wvis - pops) & 31;
            chk("level", rd_level, mlvl);
            chk("aempty", aempty, mlvl <= TH);
            chk("empty", empty, !m_valid);
            chk("rptr_gray", rptr_gray, gray5(issued));
            chk("ptr_err_clean", ptr_err, 0);
            if (ram_ren) begin
                chk("ren_with_data", ((wvis - issued) & 31) != 0, 1);
                chk("raddr", ram_raddr, issued % 16);
                issued = (issued + 1) % 32;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", m_data, 0);
                    chk("pop_unexpected_cnt", 1, 0);
                end else begin
                    mexp = exp_q.pop_front();
                    chk("data", m_data, mexp);
                end
                pops = (pops + 1) % 32;
            end
            chk("held_le_2", ((issued - pops) & 31) <= 2, 1);
        end
    end

    task automatic drain(input string name, input int limit);
        @(posedge clk_sys); #1;
        m_ready = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_sys);
            if (exp_q.size() == 0 && !m_valid) break;
        end
        @(negedge clk_sys);
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk_sys); #1;
        rst = 1'b1;
        exp_q.delete();
        wptr = 0;
        wptr_gray_sync = '0;
        repeat (2) @(posedge clk_sys);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    int            nren;
    int            w0;
    int            seen_lo;
    int            seen_rise;
    int            stuck;
    logic [DW-1:0] first_w;
    logic [3:0]    addrs [8];

    initial begin
        // Reset with two words already written (write pointer Gray 5'b00011).
        write_word($urandom);
        write_word($urandom);
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk_sys);
            chk("rst_ren", ram_ren, 0);
            chk("rst_mvalid", m_valid, 0);
            chk("rst_empty", empty, 1);
            chk("rst_level", rd_level, 0);
            chk("rst_aempty", aempty, 1);
            chk("rst_ptr_err", ptr_err, 0);
        end
        @(posedge clk_sys); #1 rst = 1'b0;
        @(negedge clk_sys); chk("rel_ren_c0", ram_ren, 0);
        @(negedge clk_sys); chk("rel_ren_c1", ram_ren, 1);
        drain("rst_drain", 30);

        // Single word latency.
        @(posedge clk_sys); #1;
        w0 = wptr;
        write_word($urandom);
        @(negedge clk_sys); chk("sw_ren_t", ram_ren, 0);
        @(negedge clk_sys); chk("sw_ren_t1", ram_ren, 1); chk("sw_addr_t1", ram_raddr, w0 % 16);
        @(negedge clk_sys); chk("sw_rptr_gray_t2", rptr_gray, gray5(w0 + 1)); chk("sw_mvalid_t2", m_valid, 0);
        @(negedge clk_sys); chk("sw_mvalid_t3", m_valid, 1);
        drain("sw_drain", 20);

        // Streaming a full FIFO with the consumer always ready.
        do_reset();
        m_ready = 1'b1;
        @(posedge clk_sys); #1;
        for (int i = 0; i < 16; i++) write_word($urandom);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (m_valid) break;
        end
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk_sys);
            chk("stream_nogap", m_valid, 1);
        end
        @(negedge clk_sys);
        chk("stream_empty", empty, 1);
        chk("stream_rptr_gray", rptr_gray, 5'b11000);
        chk("stream_left", exp_q.size(), 0);

        // Backpressure: 8 words, consumer stalled.
        @(posedge clk_sys); #1;
        m_ready = 1'b0;
        first_w = $urandom;
        write_word(first_w);
        for (int i = 1; i < 8; i++) write_word($urandom);
        nren = 0;
        repeat (8) begin
            @(negedge clk_sys);
            if (ram_ren) nren++;
        end
        chk("bp_reads", nren, 2);
        chk("bp_level", rd_level, 8);
        chk("bp_mvalid", m_valid, 1);
        @(posedge clk_sys); #1 m_ready = 1'b1;
        @(negedge clk_sys);
        chk("bp_pop_ren", ram_ren, 1);
        chk("bp_pop_data", m_data, first_w);
        @(posedge clk_sys); #1 m_ready = 1'b0;
        @(negedge clk_sys);
        chk("bp_level_after", rd_level, 7);
        drain("bp_drain", 40);

        // Wrap-around: advance read pointer to 30, then four words ending at wptr 2.
        @(posedge clk_sys); #1;
        for (int i = 0; i < 6; i++) write_word($urandom);
        drain("wrap_pre_drain", 30);
        @(posedge clk_sys); #1;
        for (int i = 0; i < 4; i++) write_word($urandom);
        nren = 0;
        seen_lo = 0;
        seen_rise = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (ram_ren && nren < 8) begin
                addrs[nren] = ram_raddr;
                nren++;
            end
            if (!aempty) seen_lo = 1;
            if (seen_lo != 0 && aempty) seen_rise = 1;
        end
        chk("wrap_reads", nren, 4);
        for (int k = 0; k < 4; k++) chk("wrap_addr", addrs[k], (14 + k) % 16);
        chk("wrap_rptr_gray", rptr_gray, 5'b00011);
        chk("wrap_aempty_low", seen_lo, 1);
        chk("wrap_aempty_rise", seen_rise, 1);
        chk("wrap_left", exp_q.size(), 0);

        // Random traffic with a varying consumer.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk_sys); #1;
            m_ready = ($urandom_range(0, 3) < ((c / 250) % 4));
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                if (((wptr - g2b5(rptr_gray)) & 31) < 16) write_word($urandom);
            end
        end
        drain("rand_drain", 100);

        // Pointer inconsistency: 20 words claimed on a 16-deep FIFO.
        mon_en = 1'b0;
        w0 = wptr;
        @(posedge clk_sys); #1 wptr_gray_sync = gray5(w0 + 20);
        @(negedge clk_sys); chk("err_c0", ptr_err, 0);
        @(negedge clk_sys); chk("err_c1_ren", ram_ren, 0); chk("err_c1", ptr_err, 0);
        @(negedge clk_sys); chk("err_set", ptr_err, 1); chk("err_c2_ren", ram_ren, 0);
        @(posedge clk_sys); #1 wptr_gray_sync = gray5(w0 + 1);
        nren = 0;
        stuck = 1;
        repeat (6) begin
            @(negedge clk_sys);
            if (ram_ren) nren++;
            if (!ptr_err) stuck = 0;
        end
        chk("err_no_reads", nren, 0);
        chk("err_sticky", stuck, 1);
        chk("err_level", rd_level, 0);
        do_reset();
        @(negedge clk_sys);
        chk("err_cleared", ptr_err, 0);
        chk("err_rst_level", rd_level, 0);
        chk("err_rst_rptr_gray", rptr_gray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
